// File: rtl/sevenseg_scan_decoder_if.sv
// Bus bundle for the seven-segment scan decoder.
// master: drives the observed display bus (enable, anodes, segments) and reads
//         the decoded results.
// slave : the decoder itself; samples the display bus and drives bcd_word,
//         digit_valid, frame_valid, error and err_count.
interface sevenseg_scan_decoder_if;
  logic        enable;
  logic [7:0]  anodes;       // active-low digit select
  logic [6:0]  segments;     // {A,B,C,D,E,F,G}, 1 = lit
  logic [31:0] bcd_word;     // digit i at [4i+3:4i]
  logic [7:0]  digit_valid;
  logic        frame_valid;
  logic        error;
  logic [7:0]  err_count;

  modport master (
    output enable, anodes, segments,
    input  bcd_word, digit_valid, frame_valid, error, err_count
  );

  modport slave (
    input  enable, anodes, segments,
    output bcd_word, digit_valid, frame_valid, error, err_count
  );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed 8-digit display bus,
// captures each digit once it has been stable for STABLE_CYCLES samples,
// decodes the segment pattern to BCD and tracks frame completion.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - slave modport: enable/anodes/segments in; bcd_word,
//              digit_valid, frame_valid, error, err_count out
module sevenseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  sevenseg_scan_decoder_if.slave bus
);

  localparam logic [3:0] StableMax  = 4'(STABLE_CYCLES);
  localparam logic [3:0] StablePrev = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CodeIllegal = 4'hE;
  localparam logic [3:0] CodeBlank   = 4'hF;

  function automatic logic [3:0] decode_seg(input logic [6:0] seg);
    logic [3:0] code;
    case (seg)
      7'b1111110: code = 4'd0;
      7'b0110000: code = 4'd1;
      7'b1101101: code = 4'd2;
      7'b1111001: code = 4'd3;
      7'b0110011: code = 4'd4;
      7'b1011011: code = 4'd5;
      7'b0011111: code = 4'd6;
      7'b1110000: code = 4'd7;
      7'b1111111: code = 4'd8;
      7'b1110011: code = 4'd9;
      7'b0000000: code = CodeBlank;
      default:    code = CodeIllegal;
    endcase
    return code;
  endfunction

  logic [14:0] sample_d, sample_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [31:0] bcd_d, bcd_q;
  logic [7:0]  dv_d, dv_q;
  logic [7:0]  mask_d, mask_q;
  logic        fv_d, fv_q;
  logic        err_d, err_q;
  logic [7:0]  errcnt_d, errcnt_q;

  logic [7:0]  sel_oh;
  logic        selecting;
  logic        same;
  logic        capture;
  logic [2:0]  sel_idx;
  logic [3:0]  code;
  logic        mask_full;

  assign sample_d = {bus.anodes, bus.segments};

  // Exactly one anode low: nonzero and a power of two once inverted.
  assign sel_oh    = ~bus.anodes;
  assign selecting = (sel_oh != 8'd0) && ((sel_oh & (sel_oh - 8'd1)) == 8'd0);
  assign same      = (sample_d == sample_q);

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.anodes[i]) sel_idx = 3'(i);
    end
  end

  // Counter clears on any change, idle bus or disable; saturates at the window length.
  always_comb begin
    cnt_d = 4'd0;
    if (bus.enable && selecting && same) begin
      cnt_d = (cnt_q == StableMax) ? StableMax : cnt_q + 4'd1;
    end
  end

  // Fires only on the edge where the counter steps into saturation.
  assign capture   = bus.enable && selecting && same && (cnt_q == StablePrev);
  assign code      = decode_seg(bus.segments);
  assign mask_full = (mask_q == 8'hFF);

  always_comb begin
    bcd_d    = bcd_q;
    dv_d     = dv_q;
    errcnt_d = errcnt_q;
    err_d    = 1'b0;
    // A full mask pulses frame_valid and clears; a same-cycle capture lands in the new mask.
    fv_d     = mask_full;
    mask_d   = mask_full ? 8'd0 : mask_q;
    if (!bus.enable) begin
      fv_d   = 1'b0;
      mask_d = 8'd0;
    end else if (capture) begin
      bcd_d[{sel_idx, 2'b00} +: 4] = code;
      dv_d[sel_idx]                = (code <= 4'd9);
      mask_d[sel_idx]              = 1'b1;
      if (code == CodeIllegal) begin
        err_d = 1'b1;
        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end
    end
  end

  // Sample resets to an idle bus so a fresh full window is needed after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '1;
      cnt_q    <= 4'd0;
      bcd_q    <= 32'hFFFF_FFFF;
      dv_q     <= 8'd0;
      mask_q   <= 8'd0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      dv_q     <= dv_d;
      mask_q   <= mask_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign bus.bcd_word    = bcd_q;
  assign bus.digit_valid = dv_q;
  assign bus.frame_valid = fv_q;
  assign bus.error       = err_q;
  assign bus.err_count   = errcnt_q;

endmodule
